// File: rtl/sync_pkg.sv
// Shared constants and helpers for the synchronizer/filter blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sync_pkg;

  // Legal synchronizer depth range for sync_filter_edge.
  localparam int STAGES_MIN = 2;
  localparam int STAGES_MAX = 4;

  // Ceiling log2. clog2(n) is the number of bits needed to hold 0..n-1,
  // so the counter width for a terminal count C is clog2(C+1).
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// One channel: synchronizer chain, glitch filter counter, filtered level and edge pulses.
// Latency: stable input reaches data_out STAGES+FILTER_CNT+1 edges after the first capture.
// Backpressure: none; pulses are single-cycle and cannot be stalled.
//
// Ports:
//   clock, reset_l  destination clock, async active-low reset
//   data_in         raw asynchronous bit
//   data_out        synchronized, filtered level
//   rise, fall      one-cycle pulses on data_out transitions
//   change_nxt      combinational "data_out changes at the next edge", lets the
//                   parent register any_change in the same cycle as the pulses
module sync_filter_chan
  import sync_pkg::*;
#(
  parameter int   STAGES     = 2,
  parameter int   FILTER_CNT = 0,
  parameter int   CNT_MSB    = 3,
  parameter logic RESET_VAL  = 1'b0
) (
  input  logic clock,
  input  logic reset_l,
  input  logic data_in,
  output logic data_out,
  output logic rise,
  output logic fall,
  output logic change_nxt
);

  localparam logic [CNT_MSB:0] CNT_LIMIT = (CNT_MSB+1)'(FILTER_CNT);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
  logic [CNT_MSB:0] cnt;
  logic             s;
  logic             mismatch;
  logic             terminal;

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], data_in};
    end
  end

  assign s = sync_q[STAGES-1];

  always_comb begin
    mismatch = 1'b0;
    terminal = 1'b0;
    mismatch = (s != data_out);
    // Terminal only when the mismatch has already been seen FILTER_CNT times,
    // so cnt tops out at CNT_LIMIT and never wraps.
    terminal = mismatch && (cnt == CNT_LIMIT);
  end

  assign change_nxt = terminal;

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      cnt      <= '0;
      data_out <= RESET_VAL;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (!mismatch) begin
        // Returning to the current level abandons any partial count.
        cnt <= '0;
      end else if (!terminal) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt      <= '0;
        data_out <= s;
        rise     <= s;
        fall     <= ~s;
      end
    end
  end

endmodule

// File: rtl/sync_filter_edge.sv
// Multi-channel async input conditioner: per-bit synchronizer, glitch filter, edge pulses.
// Latency: data_out/rise/fall/any_change follow a stable input by STAGES+FILTER_CNT+1 edges.
// Backpressure: none; every output is a free-running registered indication.
//
// Ports:
//   clock, reset_l  destination clock, async active-low reset
//   data_in         asynchronous inputs (independent single-bit signals, not a coherent bus)
//   data_out        synchronized, filtered levels
//   rise, fall      per-channel one-cycle transition pulses
//   any_change      registered OR of all rise|fall, aligned with the pulses
module sync_filter_edge
  import sync_pkg::*;
#(
  parameter int   WIDTH_MSB  = 0,
  parameter int   STAGES     = 2,
  parameter int   FILTER_CNT = 0,
  parameter int   CNT_MSB    = 3,
  parameter logic RESET_VAL  = 1'b0
) (
  input  logic             clock,
  input  logic             reset_l,
  input  logic [WIDTH_MSB:0] data_in,
  output logic [WIDTH_MSB:0] data_out,
  output logic [WIDTH_MSB:0] rise,
  output logic [WIDTH_MSB:0] fall,
  output logic             any_change
);

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("sync_filter_edge: STAGES=%0d outside %0d..%0d", STAGES, STAGES_MIN, STAGES_MAX);
  end

  if (FILTER_CNT < 0 || clog2(FILTER_CNT + 1) > CNT_MSB + 1) begin : g_bad_filter
    $error("sync_filter_edge: FILTER_CNT=%0d does not fit a %0d-bit counter",
           FILTER_CNT, CNT_MSB + 1);
  end

  logic [WIDTH_MSB:0] change_nxt;

  for (genvar i = 0; i <= WIDTH_MSB; i++) begin : g_chan
    sync_filter_chan #(
      .STAGES     (STAGES),
      .FILTER_CNT (FILTER_CNT),
      .CNT_MSB    (CNT_MSB),
      .RESET_VAL  (RESET_VAL)
    ) u_chan (
      .clock      (clock),
      .reset_l    (reset_l),
      .data_in    (data_in[i]),
      .data_out   (data_out[i]),
      .rise       (rise[i]),
      .fall       (fall[i]),
      .change_nxt (change_nxt[i])
    );
  end

  // Registered from the channels' next-state change flags so it lands in the
  // same cycle as the rise/fall pulses rather than one cycle behind them.
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      any_change <= 1'b0;
    end else begin
      any_change <= |change_nxt;
    end
  end

endmodule

// File: tb/tb_sync_filter_edge.sv
// Directed bench for sync_filter_edge across several parameterisations.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_sync_filter_edge;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_l;

  int n_cmp = 0;
  int n_bad = 0;

  // A: RESET_VAL=1, defaults otherwise
  logic din_a, dout_a, rise_a, fall_a, any_a;
  // B: all defaults
  logic din_b, dout_b, rise_b, fall_b, any_b;
  // C: FILTER_CNT=3
  logic din_c, dout_c, rise_c, fall_c, any_c;
  // D: WIDTH_MSB=3
  logic [3:0] din_d, dout_d, rise_d, fall_d;
  logic       any_d;
  // E: FILTER_CNT=5
  logic din_e, dout_e, rise_e, fall_e, any_e;
  // F: STAGES=3, WIDTH_MSB=1
  logic [1:0] din_f, dout_f, rise_f, fall_f;
  logic       any_f;

  sync_filter_edge #(.RESET_VAL(1'b1)) u_a (
    .clock(clock), .reset_l(reset_l), .data_in(din_a), .data_out(dout_a),
    .rise(rise_a), .fall(fall_a), .any_change(any_a));

  sync_filter_edge u_b (
    .clock(clock), .reset_l(reset_l), .data_in(din_b), .data_out(dout_b),
    .rise(rise_b), .fall(fall_b), .any_change(any_b));

  sync_filter_edge #(.FILTER_CNT(3)) u_c (
    .clock(clock), .reset_l(reset_l), .data_in(din_c), .data_out(dout_c),
    .rise(rise_c), .fall(fall_c), .any_change(any_c));

  sync_filter_edge #(.WIDTH_MSB(3)) u_d (
    .clock(clock), .reset_l(reset_l), .data_in(din_d), .data_out(dout_d),
    .rise(rise_d), .fall(fall_d), .any_change(any_d));

  sync_filter_edge #(.FILTER_CNT(5)) u_e (
    .clock(clock), .reset_l(reset_l), .data_in(din_e), .data_out(dout_e),
    .rise(rise_e), .fall(fall_e), .any_change(any_e));

  sync_filter_edge #(.WIDTH_MSB(1), .STAGES(3)) u_f (
    .clock(clock), .reset_l(reset_l), .data_in(din_f), .data_out(dout_f),
    .rise(rise_f), .fall(fall_f), .any_change(any_f));

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic v;
    reset_l = 1'b0;
    din_a = 1'b1;
    din_b = 1'b0;
    din_c = 1'b0;
    din_d = 4'b0000;
    din_e = 1'b0;
    din_f = 2'b00;
    v     = 1'b0;
    step();
    step();

    // ---- reset state
    check("rst_a_dout", 32'(dout_a), 32'd1);
    check("rst_a_rise", 32'(rise_a), 32'd0);
    check("rst_a_fall", 32'(fall_a), 32'd0);
    check("rst_a_any",  32'(any_a),  32'd0);
    check("rst_d_dout", 32'(dout_d), 32'h0);
    check("rst_f_dout", 32'(dout_f), 32'h0);

    // ---- test 1: RESET_VAL=1, no pulse on release
    reset_l = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      step();
      check("t1_rel_dout", 32'(dout_a), 32'd1);
      check("t1_rel_pulse", 32'({rise_a, fall_a, any_a}), 32'd0);
    end
    // fall in flight, then reset mid-run discards it immediately
    din_a = 1'b0;
    step();
    step();
    step();
    check("t1_fall_dout", 32'(dout_a), 32'd0);
    check("t1_fall_pulse", 32'(fall_a), 32'd1);
    check("t1_fall_any", 32'(any_a), 32'd1);
    reset_l = 1'b0;
    #1;
    check("t1_mid_dout", 32'(dout_a), 32'd1);
    check("t1_mid_pulse", 32'({rise_a, fall_a, any_a}), 32'd0);
    din_a = 1'b1;
    step();
    step();
    check("t1_hold_dout", 32'(dout_a), 32'd1);
    check("t1_hold_pulse", 32'({rise_a, fall_a, any_a}), 32'd0);
    reset_l = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      step();
      check("t1_rel2_dout", 32'(dout_a), 32'd1);
      check("t1_rel2_pulse", 32'({rise_a, fall_a, any_a}), 32'd0);
    end

    // ---- test 2: defaults, rise at edge 3
    din_b = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      step();
      check("t2_dout", 32'(dout_b), 32'(e >= 3));
      check("t2_rise", 32'(rise_b), 32'(e == 3));
      check("t2_fall", 32'(fall_b), 32'd0);
      check("t2_any",  32'(any_b),  32'(e == 3));
    end

    // ---- test 3: FILTER_CNT=3, 3-cycle excursion discarded
    din_c = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (e == 3) din_c = 1'b0;
      check("t3_glitch_dout", 32'(dout_c), 32'd0);
      check("t3_glitch_pulse", 32'({rise_c, fall_c, any_c}), 32'd0);
    end
    // 4-cycle excursion propagates at edge 6, falls back at edge 10
    din_c = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (e == 4) din_c = 1'b0;
      check("t3_dout", 32'(dout_c), 32'(e >= 6 && e < 10));
      check("t3_rise", 32'(rise_c), 32'(e == 6));
      check("t3_fall", 32'(fall_c), 32'(e == 10));
      check("t3_any",  32'(any_c),  32'(e == 6 || e == 10));
    end

    // ---- test 4: simultaneous rise and fall on different bits
    din_d = 4'b0101;
    repeat (5) step();
    check("t4_settle", 32'(dout_d), 32'h5);
    din_d = 4'b1010;
    for (int e = 1; e <= 4; e++) begin
      step();
      check("t4_dout", 32'(dout_d), (e >= 3) ? 32'hA : 32'h5);
      check("t4_rise", 32'(rise_d), (e == 3) ? 32'hA : 32'h0);
      check("t4_fall", 32'(fall_d), (e == 3) ? 32'h5 : 32'h0);
      check("t4_any",  32'(any_d),  32'(e == 3));
    end

    // ---- test 5: FILTER_CNT=5, reset at cnt=3 restarts the count
    din_e = 1'b1;
    repeat (5) step();
    check("t5_pre_dout", 32'(dout_e), 32'd0);
    reset_l = 1'b0;
    step();
    check("t5_rst_dout", 32'(dout_e), 32'd0);
    reset_l = 1'b1;
    for (int r = 1; r <= 9; r++) begin
      step();
      check("t5_dout", 32'(dout_e), 32'(r >= 8));
      check("t5_rise", 32'(rise_e), 32'(r == 8));
      check("t5_any",  32'(any_e),  32'(r == 8));
    end

    // ---- test 6: STAGES=3, bit 1 toggles every 8 cycles, 4-edge lag
    for (int t = 0; t < 4; t++) begin
      v = ~v;
      din_f[1] = v;
      for (int e = 1; e <= 8; e++) begin
        step();
        check("t6_dout", 32'(dout_f), 32'({(e >= 4) ? v : ~v, 1'b0}));
        check("t6_rise", 32'(rise_f), 32'({(e == 4) && v, 1'b0}));
        check("t6_fall", 32'(fall_f), 32'({(e == 4) && !v, 1'b0}));
        check("t6_any",  32'(any_f),  32'(e == 4));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
